shift_issue_queue: RTL

Command buffer and result register wrapped around the 16-bit combinational `Shifter`. It sits directly upstream of the shifter and buffers up to DEPTH shift commands behind a valid/ready handshake. It drives the head command onto the shifter's `src`/`arith`/`amt` inputs and captures `res` into a registered, handshaked output with zero/negative flags. This decouples the variable-rate producer (decode/execute) from the shifter and from the consumer.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_issue_queue_if.sv | 38 +++
 rtl/shift_cmd_fifo.sv | 59 +++++
 rtl/shift_issue_queue.sv | 87 ++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and widths for the shift command queue and its shifter interface.
package shift_pkg;

   localparam int unsigned SHW  = 16;
   localparam int unsigned AMTW = 4;

   typedef struct packed {
      logic [SHW-1:0]  src;
      logic            arith;
      logic [AMTW-1:0] amt;
   } shift_cmd_t;

   function automatic logic res_is_zero(logic [SHW-1:0] v);
      return v == '0;
   endfunction

endpackage

// File: rtl/shift_issue_queue_if.sv
// Command, shifter and result handshake bundle for shift_issue_queue.
interface shift_issue_queue_if #(
   parameter int unsigned Depth = 4
);
   import shift_pkg::*;

   localparam int unsigned CntW = $clog2(Depth) + 1;

   logic            cmd_valid;
   logic            cmd_ready;
   logic [SHW-1:0]  cmd_src;
   logic            cmd_arith;
   logic [AMTW-1:0] cmd_amt;

   logic [SHW-1:0]  sh_src;
   logic            sh_arith;
   logic [AMTW-1:0] sh_amt;
   logic [SHW-1:0]  sh_res;

   logic            res_valid;
   logic            res_ready;
   logic [SHW-1:0]  res_data;
   logic            res_zero;
   logic            res_neg;

   logic [CntW-1:0] count;

   modport slave (
      input  cmd_valid, cmd_src, cmd_arith, cmd_amt, sh_res, res_ready,
      output cmd_ready, sh_src, sh_arith, sh_amt, res_valid, res_data, res_zero, res_neg, count
   );

   modport master (
      output cmd_valid, cmd_src, cmd_arith, cmd_amt, sh_res, res_ready,
      input  cmd_ready, sh_src, sh_arith, sh_amt, res_valid, res_data, res_zero, res_neg, count
   );

endinterface

// File: rtl/shift_cmd_fifo.sv
// Synchronous FIFO of shift commands; Depth must be a power of two so pointers wrap naturally.
module shift_cmd_fifo
   import shift_pkg::*;
#(
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  shift_cmd_t      data_i,
   input  logic            pop_i,
   output shift_cmd_t      head_o,
   output logic [CntW-1:0] count_o,
   output logic            full_o,
   output logic            empty_o
);

   shift_cmd_t      mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push_ok, pop_ok;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A full queue refuses a push even if the head leaves in the same cycle.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
      rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
      count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/shift_issue_queue.sv
// Command queue in front of an external combinational shifter, with a registered,
// handshaked result and zero/negative flags.
module shift_issue_queue
   import shift_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   shift_issue_queue_if.slave  bus_io
);

   localparam int unsigned CntW = $clog2(Depth) + 1;

   shift_cmd_t      cmd_in;
   shift_cmd_t      head;
   logic [CntW-1:0] fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   logic            load;

   logic            res_valid_q, res_valid_d;
   logic [SHW-1:0]  res_data_q, res_data_d;
   logic            res_zero_q, res_zero_d;
   logic            res_neg_q, res_neg_d;

   assign cmd_in.src   = bus_io.cmd_src;
   assign cmd_in.arith = bus_io.cmd_arith;
   assign cmd_in.amt   = bus_io.cmd_amt;

   // Head leaves the queue whenever the output register is empty or being drained.
   assign load = !fifo_empty && (!res_valid_q || bus_io.res_ready);

   shift_cmd_fifo #(
      .Depth (Depth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (bus_io.cmd_valid),
      .data_i  (cmd_in),
      .pop_i   (load),
      .head_o  (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_zero_d  = res_zero_q;
      res_neg_d   = res_neg_q;
      if (load) begin
         res_valid_d = 1'b1;
         res_data_d  = bus_io.sh_res;
         res_zero_d  = res_is_zero(bus_io.sh_res);
         res_neg_d   = bus_io.sh_res[SHW-1];
      end else if (res_valid_q && bus_io.res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_zero_q  <= 1'b0;
         res_neg_q   <= 1'b0;
      end else begin
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_zero_q  <= res_zero_d;
         res_neg_q   <= res_neg_d;
      end
   end

   assign bus_io.cmd_ready = !fifo_full;
   assign bus_io.count     = fifo_count;
   assign bus_io.sh_src    = fifo_empty ? '0 : head.src;
   assign bus_io.sh_arith  = fifo_empty ? 1'b0 : head.arith;
   assign bus_io.sh_amt    = fifo_empty ? '0 : head.amt;
   assign bus_io.res_valid = res_valid_q;
   assign bus_io.res_data  = res_data_q;
   assign bus_io.res_zero  = res_zero_q;
   assign bus_io.res_neg   = res_neg_q;

endmodule
